// File: rtl/debug_monitor.sv
// Multi-channel debug monitor: sticky error flags, saturating edge counters,
// and a periodic checksummed telemetry frame streamed over valid/ready.
module debug_monitor #(
    parameter int         NUM_CH       = 2,
    parameter int         DATA_W       = 32,
    parameter int         FRAME_PERIOD = 1024,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_error,
    input  logic                     clear_sticky,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [NUM_CH-1:0]        sticky_err,
    output logic                     err_any,
    output logic [DATA_W-1:0]        debug_data_out
);

    localparam int BPC   = DATA_W / 8;
    localparam int TMR_W = $clog2(FRAME_PERIOD);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DB_W  = (BPC > 1) ? $clog2(BPC) : 1;

    typedef enum logic [2:0] {IDLE, HDR, CH_CNT, CH_DATA, CSUM} state_t;

    state_t              r_state, w_state_nxt;
    logic [NUM_CH-1:0]   r_err_prev, r_sticky;
    logic [7:0]          r_cnt [NUM_CH];
    logic [TMR_W-1:0]    r_timer;
    logic [1:0]          r_hdr_idx;
    logic [CH_W-1:0]     r_ch_idx;
    logic [DB_W-1:0]     r_byte_idx;
    logic [7:0]          r_csum;
    logic [6:0]          r_seq;
    logic                r_overrun;
    logic                r_err_any;
    logic [DATA_W-1:0]   r_debug;

    logic [7:0]          r_sh_data [NUM_CH][BPC];
    logic [7:0]          r_sh_cnt [NUM_CH];
    logic [7:0]          r_sh_sticky;
    logic                r_sh_ovr;

    logic [NUM_CH-1:0]   w_rise;
    logic                w_tick, w_snap, w_xfer, w_last_byte, w_last_ch;

    assign w_rise      = ch_error & ~r_err_prev;
    assign w_tick      = (r_timer == TMR_W'(FRAME_PERIOD - 1));
    assign w_snap      = w_tick && (r_state == IDLE);
    assign tx_valid    = (r_state != IDLE);
    assign w_xfer      = tx_valid && tx_ready;
    assign w_last_byte = (r_byte_idx == DB_W'(BPC - 1));
    assign w_last_ch   = (r_ch_idx == CH_W'(NUM_CH - 1));

    assign sticky_err     = r_sticky;
    assign err_any        = r_err_any;
    assign debug_data_out = r_debug;

    // A set in the same cycle as clear_sticky wins over the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_prev <= '0;
            r_sticky   <= '0;
            r_err_any  <= 1'b0;
            r_debug    <= '0;
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_err_prev <= ch_error;
            r_err_any  <= |r_sticky;
            r_debug    <= {r_sticky, ch_data[DATA_W-NUM_CH-1:0]};
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_error[i])       r_sticky[i] <= 1'b1;
                else if (clear_sticky) r_sticky[i] <= 1'b0;
                if (clear_sticky)
                    r_cnt[i] <= {7'd0, w_rise[i]};
                else if (w_rise[i] && (r_cnt[i] != 8'hFF))
                    r_cnt[i] <= r_cnt[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        tx_data     = 8'h00;
        case (r_state)
            IDLE: if (w_tick) w_state_nxt = HDR;
            HDR: begin
                case (r_hdr_idx)
                    2'd0:    tx_data = SYNC_BYTE;
                    2'd1:    tx_data = {r_sh_ovr, r_seq};
                    default: tx_data = r_sh_sticky;
                endcase
                if (w_xfer && (r_hdr_idx == 2'd2)) w_state_nxt = CH_CNT;
            end
            CH_CNT: begin
                tx_data = r_sh_cnt[r_ch_idx];
                if (w_xfer) w_state_nxt = CH_DATA;
            end
            CH_DATA: begin
                tx_data = r_sh_data[r_ch_idx][r_byte_idx];
                if (w_xfer && w_last_byte) w_state_nxt = w_last_ch ? CSUM : CH_CNT;
            end
            CSUM: begin
                tx_data = r_csum;
                if (w_xfer) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Timer, frame indices, running checksum, sequence and overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer    <= '0;
            r_hdr_idx  <= '0;
            r_ch_idx   <= '0;
            r_byte_idx <= '0;
            r_csum     <= '0;
            r_seq      <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_timer <= w_tick ? '0 : r_timer + TMR_W'(1);
            if (w_tick) r_overrun <= tx_valid;
            if (w_snap) begin
                r_hdr_idx  <= '0;
                r_ch_idx   <= '0;
                r_byte_idx <= '0;
                r_csum     <= '0;
            end else if (w_xfer) begin
                r_csum <= r_csum ^ tx_data;
                case (r_state)
                    HDR:     r_hdr_idx <= r_hdr_idx + 2'd1;
                    CH_DATA: begin
                        r_byte_idx <= w_last_byte ? '0 : r_byte_idx + DB_W'(1);
                        if (w_last_byte) r_ch_idx <= r_ch_idx + CH_W'(1);
                    end
                    CSUM:    r_seq <= r_seq + 7'd1;
                    default: ;
                endcase
            end
        end
    end

    // NOTE: shadow storage has no reset; it is always loaded at snapshot before it is read.
    always_ff @(posedge clk) begin
        if (w_snap) begin
            r_sh_ovr    <= r_overrun;
            r_sh_sticky <= 8'(r_sticky);
            for (int c = 0; c < NUM_CH; c++) begin
                r_sh_cnt[c] <= r_cnt[c];
                for (int b = 0; b < BPC; b++)
                    r_sh_data[c][b] <= ch_data[c*DATA_W + DATA_W - 8*(b+1) +: 8];
            end
        end
    end

endmodule

// File: tb/tb_debug_monitor.sv
// Directed bench for debug_monitor (2 channels x 32 bits, 32-cycle frame period).
module tb_debug_monitor;

    localparam logic [31:0] CH0 = 32'h12345678;
    localparam logic [31:0] CH1 = 32'hCAFEF00D;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] ch_data;
    logic [1:0]  ch_error;
    logic        clear_sticky;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  sticky_err;
    logic        err_any;
    logic [31:0] debug_data_out;

    int          checks = 0;
    int          errors = 0;
    logic [6:0]  exp_seq;
    logic [7:0]  q [$];

    debug_monitor #(
        .NUM_CH(2), .DATA_W(32), .FRAME_PERIOD(32), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk), .reset(reset), .ch_data(ch_data), .ch_error(ch_error),
        .clear_sticky(clear_sticky), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .sticky_err(sticky_err), .err_any(err_any),
        .debug_data_out(debug_data_out)
    );

    always #5 clk = ~clk;

    // Log every byte that will transfer on the next rising edge.
    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) q.push_back(tx_data);
    end

    function automatic logic [111:0] model(input logic ovr, input logic [6:0] seq,
                                           input logic [1:0] st, input logic [7:0] c0,
                                           input logic [7:0] c1);
        logic [7:0]   b [14];
        logic [7:0]   x;
        logic [111:0] p;
        b[0] = 8'hA5;  b[1] = {ovr, seq};  b[2] = {6'd0, st};  b[3] = c0;
        b[4] = CH0[31:24]; b[5] = CH0[23:16]; b[6] = CH0[15:8]; b[7] = CH0[7:0];
        b[8] = c1;
        b[9] = CH1[31:24]; b[10] = CH1[23:16]; b[11] = CH1[15:8]; b[12] = CH1[7:0];
        x = 8'h00;
        for (int i = 0; i < 13; i++) x = x ^ b[i];
        b[13] = x;
        p = '0;
        for (int i = 0; i < 14; i++) p = {p[103:0], b[i]};
        return p;
    endfunction

    function automatic logic [111:0] pack(input logic [7:0] f [14]);
        logic [111:0] p;
        p = '0;
        for (int i = 0; i < 14; i++) p = {p[103:0], f[i]};
        return p;
    endfunction

    task automatic pop_frame(output logic [7:0] f [14], output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (n < 300 && q.size() < 14) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 14; i++) f[i] = 8'h00;
        if (q.size() >= 14) begin
            ok = 1'b1;
            for (int i = 0; i < 14; i++) f[i] = q.pop_front();
        end
    endtask

    // Returns at #1 in the first cycle of a newly started frame.
    task automatic wait_frame_start(output bit ok);
        logic prev;
        ok = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        prev = tx_valid;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (tx_valid && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = tx_valid;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; ch_data = {CH1, CH0}; ch_error = 2'b00;
        clear_sticky = 1'b0; tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00 || sticky_err !== 2'b00 ||
            err_any !== 1'b0 || debug_data_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h sticky=%b any=%b dbg=%h expected all zero",
                     tx_valid, tx_data, sticky_err, err_any, debug_data_out);
        end
        reset = 1'b0;
    endtask

    task automatic test_baseline;
        logic [7:0] exp_b [14];
        exp_b = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78,
                  8'h00, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h64};
        repeat (31) @(posedge clk);
        #1;
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL baseline_quiet_c31: got tx_valid=%b expected 0", tx_valid);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
                errors++;
                $display("FAIL baseline_byte%0d: got valid=%b data=%h expected valid=1 data=%h",
                         i, tx_valid, tx_data, exp_b[i]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL baseline_end: got tx_valid=%b expected 0", tx_valid);
        end
        q.delete();
        exp_seq = 7'd1;
    endtask

    task automatic test_errors;
        logic [11:0]  pat;
        logic [7:0]   got [14];
        bit           ok;
        pat = 12'b1010_1011_1110;
        for (int i = 0; i < 12; i++) begin
            ch_error[1] = pat[11-i];
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sticky_err !== 2'b10 || err_any !== 1'b1 || debug_data_out !== 32'h92345678) begin
            errors++;
            $display("FAIL errors_flags: got sticky=%b any=%b dbg=%h expected 10 1 92345678",
                     sticky_err, err_any, debug_data_out);
        end
        pop_frame(got, ok);
        checks++;
        if (!ok || pack(got) !== model(1'b0, exp_seq, 2'b10, 8'h00, 8'h04)) begin
            errors++;
            $display("FAIL errors_frame: got %h expected %h", pack(got),
                     model(1'b0, exp_seq, 2'b10, 8'h00, 8'h04));
        end
        exp_seq++;
    endtask

    task automatic test_saturation_clear;
        logic [7:0] got [14];
        bit         ok;
        for (int i = 0; i < 300; i++) begin
            ch_error[0] = 1'b1; @(posedge clk); #1;
            ch_error[0] = 1'b0; @(posedge clk); #1;
        end
        wait_frame_start(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL sat_frame_start: got timeout expected frame"); end
        while (q.size() >= 14) begin
            pop_frame(got, ok);
            checks++;
            if (got[0] !== 8'hA5 || got[1] !== {1'b0, exp_seq}) begin
                errors++;
                $display("FAIL sat_drain_hdr: got %h %h expected a5 %h", got[0], got[1], {1'b0, exp_seq});
            end
            exp_seq++;
        end
        pop_frame(got, ok);
        checks++;
        if (!ok || pack(got) !== model(1'b0, exp_seq, 2'b11, 8'hFF, 8'h04)) begin
            errors++;
            $display("FAIL sat_frame: got %h expected %h", pack(got),
                     model(1'b0, exp_seq, 2'b11, 8'hFF, 8'h04));
        end
        exp_seq++;

        clear_sticky = 1'b1; ch_error[0] = 1'b1;
        @(posedge clk); #1;
        clear_sticky = 1'b0; ch_error[0] = 1'b0;
        checks++;
        if (sticky_err !== 2'b01) begin
            errors++;
            $display("FAIL clear_with_set: got sticky=%b expected 01", sticky_err);
        end
        wait_frame_start(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL clr_frame_start: got timeout expected frame"); end
        while (q.size() >= 14) begin
            pop_frame(got, ok);
            checks++;
            if (got[0] !== 8'hA5 || got[1] !== {1'b0, exp_seq}) begin
                errors++;
                $display("FAIL clr_drain_hdr: got %h %h expected a5 %h", got[0], got[1], {1'b0, exp_seq});
            end
            exp_seq++;
        end
        pop_frame(got, ok);
        checks++;
        if (!ok || pack(got) !== model(1'b0, exp_seq, 2'b01, 8'h01, 8'h00)) begin
            errors++;
            $display("FAIL clr_frame: got %h expected %h", pack(got),
                     model(1'b0, exp_seq, 2'b01, 8'h01, 8'h00));
        end
        exp_seq++;

        clear_sticky = 1'b1;
        @(posedge clk); #1;
        clear_sticky = 1'b0;
        checks++;
        if (sticky_err !== 2'b00) begin
            errors++;
            $display("FAIL clear_alone: got sticky=%b expected 00", sticky_err);
        end
        @(posedge clk); #1;
        checks++;
        if (err_any !== 1'b0 || debug_data_out !== CH0) begin
            errors++;
            $display("FAIL clear_alone_regs: got any=%b dbg=%h expected 0 %h", err_any, debug_data_out, CH0);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] got [14];
        bit         ok;
        wait_frame_start(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_frame_start: got timeout expected frame"); end
        while (q.size() >= 14) begin
            pop_frame(got, ok);
            checks++;
            if (got[0] !== 8'hA5 || got[1] !== {1'b0, exp_seq}) begin
                errors++;
                $display("FAIL bp_drain_hdr: got %h %h expected a5 %h", got[0], got[1], {1'b0, exp_seq});
            end
            exp_seq++;
        end
        repeat (5) @(posedge clk);
        #1;
        tx_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h34) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: got valid=%b data=%h expected 1 34", i, tx_valid, tx_data);
            end
        end
        tx_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pop_frame(got, ok);
            checks++;
            if (!ok || pack(got) !== model(k == 1, exp_seq, 2'b00, 8'h00, 8'h00)) begin
                errors++;
                $display("FAIL bp_frame%0d: got %h expected %h", k, pack(got),
                         model(k == 1, exp_seq, 2'b00, 8'h00, 8'h00));
            end
            exp_seq++;
        end
    endtask

    task automatic test_seq_wrap;
        logic [7:0] got [14];
        bit         ok;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        reset = 1'b0;
        for (int i = 0; i < 129; i++) begin
            pop_frame(got, ok);
            checks++;
            if (!ok || pack(got) !== model(1'b0, 7'(i), 2'b00, 8'h00, 8'h00)) begin
                errors++;
                $display("FAIL seq_frame%0d: got %h expected %h", i, pack(got),
                         model(1'b0, 7'(i), 2'b00, 8'h00, 8'h00));
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] got [14];
        bit         ok;
        wait_frame_start(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_frame_start: got timeout expected frame"); end
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
            errors++;
            $display("FAIL rst_abort: got valid=%b data=%h expected 0 00", tx_valid, tx_data);
        end
        @(posedge clk); #1;
        q.delete();
        reset = 1'b0;
        pop_frame(got, ok);
        checks++;
        if (!ok || pack(got) !== model(1'b0, 7'd0, 2'b00, 8'h00, 8'h00)) begin
            errors++;
            $display("FAIL rst_frame: got %h expected %h", pack(got),
                     model(1'b0, 7'd0, 2'b00, 8'h00, 8'h00));
        end
    endtask

    initial begin
        test_reset();
        test_baseline();
        test_errors();
        test_saturation_clear();
        test_backpressure();
        test_seq_wrap();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_monitor.md
Name: debug_monitor

Overview:
- Parametrised successor to the fixed two-flag debug combiner in the top level.
- Watches NUM_CH data/error-flag channels (CPU, FPGA fabric, future accelerators) and keeps sticky error flags plus saturating per-channel error counters.
- Periodically snapshots all channels and streams a checksummed telemetry frame as a byte stream over a valid/ready handshake into the UART transmitter.
- Also drives a registered parallel debug word for pins or logic analyser.

Parameters:
- NUM_CH, 2: number of monitored channels; legal 1..8.
- DATA_W, 32: per-channel data width; multiple of 8, 8..64, must exceed NUM_CH.
- FRAME_PERIOD, 1024: cycles between frame ticks; must be >= 2.
- SYNC_BYTE, 8'hA5: first byte of every frame.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- ch_data  input  NUM_CH*DATA_W  channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- ch_error  input  NUM_CH  per-channel error flag, level.
- clear_sticky  input  1  single-cycle pulse; clears sticky flags and counters.
- tx_data  output  8  frame byte to UART.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  UART accepts byte.
- sticky_err  output  NUM_CH  sticky error flags.
- err_any  output  1  OR of sticky_err, registered.
- debug_data_out  output  DATA_W  {sticky_err[NUM_CH-1:0], ch_data channel0[DATA_W-NUM_CH-1:0]}, registered.

Behaviour:
- Reset values: all outputs 0; counters, sticky flags, sequence, overrun and frame timer = 0; FSM = IDLE. Reset mid-frame aborts the frame. tx_valid is 0 in the cycle after reset is asserted. No partial frame resumes.
- Error tracking, per channel:
  - sticky[i] sets on any cycle with ch_error[i]=1.
  - cnt[i] (8 bit) increments on each rising edge of ch_error[i] (edge = current 1, previous-cycle 0; previous register resets to 0). It saturates at 0xFF.
  - clear_sticky zeroes sticky and cnt. If clear_sticky coincides with ch_error[i]=1, the set wins: sticky[i]=1. If that cycle is also a rising edge, cnt[i]=1.
- debug_data_out and err_any: one-cycle registered latency from sticky and ch_data.
- Frame timer:
  - Counts 0..FRAME_PERIOD-1, then wraps. The first post-reset cycle is count 0.
  - tick = (count == FRAME_PERIOD-1).
  - On tick with FSM in IDLE: snapshot all ch_data, cnt and sticky into shadow registers; go to HDR. tx_valid rises the next cycle.
  - On tick with FSM busy: set the overrun bit; no snapshot.
- Frame, bytes in order:
  - SYNC_BYTE.
  - {overrun, seq[6:0]}.
  - sticky zero-extended to 8 bits.
  - For ch = 0..NUM_CH-1: cnt byte, then DATA_W/8 data bytes, MSB first.
  - Checksum = XOR of all preceding frame bytes.
  - Length L = 4 + NUM_CH*(1+DATA_W/8); default 14.
- Overrun is cleared at snapshot after it has been captured into that frame's header. seq increments after the checksum byte transfers and wraps 127 -> 0.
- FSM states: IDLE -> HDR (3 bytes) -> CH_CNT -> CH_DATA (DATA_W/8 bytes) -> next channel CH_CNT, or CSUM after the last channel -> IDLE.
  - Byte and channel indices advance only on a transfer (tx_valid && tx_ready).
- Handshake:
  - tx_valid stays high continuously from HDR through CSUM; tx_ready may be held high to stream one byte per cycle.
  - While tx_valid && !tx_ready, tx_data must hold stable.
  - tx_valid never drops without a transfer, except on reset.
- Snapshot isolation: channel and error changes during a frame do not alter bytes already snapshotted. Live counters and sticky flags keep updating.
- Back-to-back ticks: a tick in the same cycle the CSUM transfer completes counts as busy (overrun). The FSM returns to IDLE for at least one cycle.

Test Plan (NUM_CH=2, DATA_W=32, FRAME_PERIOD=32):
- Baseline: reset, tx_ready=1, ch0=0x12345678, ch1=0xCAFEF00D, no errors -> tx_valid rises cycle 32 after reset release. Bytes are A5 00 00 00 12 34 56 78 00 CA FE F0 0D 64 on consecutive cycles, then tx_valid=0.
- Errors: ch1 gets 3 separate pulses plus one 5-cycle-high pulse -> cnt1=4, sticky_err=2'b10, err_any=1, debug_data_out[31:30]=2'b10. Next frame has byte2=0x02 and ch1 cnt byte 0x04.
- Saturation and clear: 300 rising edges on ch0 -> cnt0=0xFF. clear_sticky in the same cycle as a ch0 rising edge -> sticky_err[0]=1, cnt0=1. clear_sticky alone -> both flags 0.
- Backpressure and overrun: drop tx_ready for 40 cycles mid-frame -> tx_data constant throughout, no byte lost or duplicated. Next frame header byte1 = 0x80|seq, following frame header has overrun bit 0.
- Sequence wrap: run 129 frames -> header byte1 runs 0x00..0x7F, then 0x00.
- Reset mid-frame: assert reset at byte 6 -> tx_valid=0 next cycle. After release the first frame starts with A5 00 and the full checksum is correct.
